// File: rtl/rr_arb_pkg.sv
// Shared types, constants and the rotating-priority pick function for the
// four-way round-robin arbiter rr_arb4.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t GRANT = 1'b1;

    // Winner is the first set request found searching ptr, ptr+1, ... mod N_REQ.
    function automatic logic [ID_W-1:0] rot_pick(input logic [N_REQ-1:0] req,
                                                 input logic [ID_W-1:0]  ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [ID_W-1:0]    off;
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
        return ptr + off;
    endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// Combinational rotate + 4-to-2 priority encoder: picks the round-robin
// winner starting at ptr_i and flags whether any request is pending.
module rr_prio_enc4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  winner_o,
    output logic             any_req_o
);

    assign winner_o  = rot_pick(req_i, ptr_i);
    assign any_req_o = |req_i;

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded
// grant ID and done_i release. Define RR_ARB_TIMEOUT_EN for forced release.
module rr_arb4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_vld_o,
    output logic             timeout_o
);

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be at least 2");
    end

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;

    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             force_rel;
    logic             new_grant;

    rr_prio_enc4 u_enc (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        new_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                // Timeout takes the same release path as done_i.
                if (done_i || force_rel) begin
                    if (any_req) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase

        if (new_grant) begin
            state_d       = GRANT;
            gnt_d         = '0;
            gnt_d[winner] = 1'b1;
            gnt_id_d      = winner;
            ptr_d         = winner + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // A done_i in the last hold cycle is an ordinary release, not a timeout.
    assign force_rel = (state_q == GRANT) && (hold_cnt_q == HOLD_LAST) && !done_i;

    always_comb begin
        hold_cnt_d = '0;
        if (new_grant) begin
            hold_cnt_d = '0;
        end else if (state_q == GRANT && state_d == GRANT) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign timeout_o = force_rel;
`else
    assign force_rel = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign gnt_vld_o = |gnt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus randomized traffic
// checked against a behavioural owner/pointer model.
module tb_rr_arb4;

    localparam int MAX_HOLD = 16;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic       gnt_vld_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 = none), search start pointer, cycles held.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic exp_to;
    logic smp_to;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .gnt_vld_o (gnt_vld_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] q, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (q[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [1:0] m_id();
        return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    endfunction

    task automatic model_grant(input logic [3:0] q);
        m_owner = pick(q, m_ptr);
        m_ptr   = (m_owner + 1) % 4;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic r, input logic [3:0] q, input logic d);
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            if (q != 4'b0000) model_grant(q);
        end else if (d || (TO_EN && m_hold == MAX_HOLD - 1)) begin
            if (q != 4'b0000) model_grant(q);
            else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else begin
            m_hold++;
        end
    endtask

    // Drive one cycle's inputs, sample the combinational timeout before the
    // edge, advance the model at the edge and return 1 ns after it.
    task automatic tick(input logic r, input logic [3:0] q, input logic d);
        rst    = r;
        req_i  = q;
        done_i = d;
        #1;
        exp_to = TO_EN && (m_owner >= 0) && (m_hold == MAX_HOLD - 1) && !d;
        smp_to = timeout_o;
        @(posedge clk);
        model_edge(r, q, d);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 4'b1111, 1'b0);
            total++;
            if ({gnt_o, gnt_id_o, gnt_vld_o, timeout_o} !== 8'h00) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got gnt=%b id=%0d vld=%b to=%b exp all 0",
                         i, gnt_o, gnt_id_o, gnt_vld_o, timeout_o);
            end
        end
        tick(1'b0, 4'b1111, 1'b0);
        total++;
        if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0 || gnt_vld_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant got gnt=%b id=%0d vld=%b exp gnt=0001 id=0 vld=1",
                     gnt_o, gnt_id_o, gnt_vld_o);
        end
        tick(1'b0, 4'b0000, 1'b1);
        total++;
        if ({gnt_o, gnt_id_o, gnt_vld_o} !== 7'h00) begin
            bad++;
            $display("FAIL reset_release_idle got gnt=%b id=%0d vld=%b exp all 0",
                     gnt_o, gnt_id_o, gnt_vld_o);
        end
    endtask

    task automatic test_back_to_back();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1'b0, 4'b1111, 1'b1);
            total++;
            if (gnt_vld_o !== 1'b1 || gnt_id_o !== 2'(exp_seq[i]) || gnt_o !== m_gnt()) begin
                bad++;
                $display("FAIL b2b_grant step=%0d got gnt=%b id=%0d vld=%b exp gnt=%b id=%0d vld=1",
                         i, gnt_o, gnt_id_o, gnt_vld_o, m_gnt(), exp_seq[i]);
            end
        end
        tick(1'b0, 4'b0000, 1'b1);
    endtask

    task automatic test_wrap();
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b0010, 1'b0);
        tick(1'b0, 4'b0000, 1'b1);
        tick(1'b0, 4'b0011, 1'b0);
        total++;
        if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
            bad++;
            $display("FAIL wrap_past_3 got gnt=%b id=%0d exp gnt=0001 id=0", gnt_o, gnt_id_o);
        end
        tick(1'b0, 4'b0000, 1'b1);
        tick(1'b0, 4'b0011, 1'b0);
        total++;
        if (gnt_o !== 4'b0010 || gnt_id_o !== 2'd1) begin
            bad++;
            $display("FAIL wrap_next got gnt=%b id=%0d exp gnt=0010 id=1", gnt_o, gnt_id_o);
        end
        tick(1'b0, 4'b0000, 1'b1);
    endtask

    task automatic test_hold_no_revoke();
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, (i % 2 == 1) ? 4'b1101 : 4'b0000, 1'b0);
            total++;
            if (gnt_o !== 4'b0010 || gnt_id_o !== 2'd1) begin
                bad++;
                $display("FAIL hold_no_revoke cyc=%0d got gnt=%b id=%0d exp gnt=0010 id=1",
                         i, gnt_o, gnt_id_o);
            end
        end
        tick(1'b0, 4'b0000, 1'b1);
        total++;
        if ({gnt_o, gnt_id_o, gnt_vld_o} !== 7'h00) begin
            bad++;
            $display("FAIL hold_release_idle got gnt=%b id=%0d vld=%b exp all 0",
                     gnt_o, gnt_id_o, gnt_vld_o);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b0100, 1'b0);
        total++;
        if (gnt_o !== 4'b0100) begin
            bad++;
            $display("FAIL midrst_setup got gnt=%b exp 0100", gnt_o);
        end
        tick(1'b1, 4'b1111, 1'b1);
        total++;
        if ({gnt_o, gnt_id_o, gnt_vld_o} !== 7'h00) begin
            bad++;
            $display("FAIL midrst_clear got gnt=%b id=%0d vld=%b exp all 0",
                     gnt_o, gnt_id_o, gnt_vld_o);
        end
        tick(1'b0, 4'b1111, 1'b0);
        total++;
        if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
            bad++;
            $display("FAIL midrst_ptr_zero got gnt=%b id=%0d exp gnt=0001 id=0", gnt_o, gnt_id_o);
        end
        tick(1'b0, 4'b0000, 1'b1);
    endtask

    task automatic test_timeout();
        int pulse_at = 0;
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b1111, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            tick(1'b0, 4'b1111, 1'b0);
            if (smp_to === 1'b1 && pulse_at == 0) pulse_at = c;
            total++;
            if (smp_to !== exp_to || gnt_o !== m_gnt()) begin
                bad++;
                $display("FAIL timeout_track cyc=%0d got to=%b gnt=%b exp to=%b gnt=%b",
                         c, smp_to, gnt_o, exp_to, m_gnt());
            end
        end
`ifdef RR_ARB_TIMEOUT_EN
        total++;
        if (pulse_at !== 16) begin
            bad++;
            $display("FAIL timeout_pulse_cycle got %0d exp 16", pulse_at);
        end
        // done_i in the last hold cycle: normal release, no timeout pulse.
        tick(1'b1, 4'b0000, 1'b0);
        tick(1'b0, 4'b1111, 1'b0);
        for (int c = 1; c < MAX_HOLD; c++) tick(1'b0, 4'b1111, 1'b0);
        tick(1'b0, 4'b1111, 1'b1);
        total++;
        if (smp_to !== 1'b0 || gnt_o !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_done_same_edge got to=%b gnt=%b exp to=0 gnt=0010",
                     smp_to, gnt_o);
        end
`else
        total++;
        if (pulse_at !== 0 || gnt_o !== 4'b0001) begin
            bad++;
            $display("FAIL no_timeout_hold got pulse_at=%0d gnt=%b exp pulse_at=0 gnt=0001",
                     pulse_at, gnt_o);
        end
`endif
        tick(1'b0, 4'b0000, 1'b1);
    endtask

    task automatic test_random();
        logic       r;
        logic [3:0] q;
        logic       d;
        tick(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(63) == 0);
            q = ($urandom_range(3) == 0) ? 4'b0000 : 4'($urandom_range(15));
            d = ($urandom_range(3) == 0);
            tick(r, q, d);
            total++;
            if (gnt_o !== m_gnt() || gnt_id_o !== m_id() || gnt_vld_o !== (m_owner >= 0)
                || smp_to !== exp_to) begin
                bad++;
                $display("FAIL random cyc=%0d got gnt=%b id=%0d vld=%b to=%b exp gnt=%b id=%0d vld=%b to=%b",
                         i, gnt_o, gnt_id_o, gnt_vld_o, smp_to, m_gnt(), m_id(), (m_owner >= 0), exp_to);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        req_i  = 4'b0000;
        done_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_hold_no_revoke();
        test_reset_mid_grant();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
